ros_scan_readout: RTL

//   Parametrised successor to the single-channel ring-oscillator readout. It owns the full measurement cycle:

---
 rtl/ros_scan_readout_if.sv | 18 +
 rtl/ros_scan_readout.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ros_scan_readout_if.sv
// ----------------------------------------------------------------------------
// ros_scan_readout_if
//   Serial frame stream leaving the ring-oscillator scan readout.
//   master : the readout block that drives the stream
//   slave  : the pin driver or a monitor that receives it
// Signals
//   ser_data    frame bit, MSB first
//   ser_valid   ser_data carries a frame bit this cycle
//   frame_start high together with the first (header MSB) bit of each frame
// ----------------------------------------------------------------------------
interface ros_scan_readout_if;
  logic ser_data;
  logic ser_valid;
  logic frame_start;

  modport master (output ser_data, output ser_valid, output frame_start);
  modport slave  (input  ser_data, input  ser_valid, input  frame_start);
endinterface

// File: rtl/ros_scan_readout.sv
// ----------------------------------------------------------------------------
// ros_scan_readout
//   Runs the complete ring-oscillator measurement cycle for NUM_CH channels:
//   clear the channel counters, open the gate window, let the counts settle,
//   snapshot every counter, then send one framed, parity-protected word per
//   enabled channel. Single-shot or continuous scanning.
//
//   Frame (MSB first): {4'b1010, idx[IDX_W-1:0], count[CNT_W-1:0], par}
//   with par = ^{idx, count} (even parity over index and count).
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   ena         in   design enable; low freezes every register
//   start       in   scan request, only looked at in IDLE
//   continuous  in   keep rescanning after each sweep while high
//   ch_mask     in   NUM_CH bits, bit i selects channel i for readout
//   win_len     in   gate-high length in clk cycles (0 behaves as 1)
//   cnt_in      in   channel counts, channel i at [i*CNT_W +: CNT_W]
//   ctr_clear   out  one-cycle clear pulse to the channel counters
//   gate        out  measurement window to the channels
//   busy        out  high whenever the sequencer is not in IDLE
//   done        out  one-cycle pulse after the last bit of a sweep
//   ser         ros_scan_readout_if.master: ser_data / ser_valid / frame_start
// ----------------------------------------------------------------------------
module ros_scan_readout #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic                    start,
  input  logic                    continuous,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [WIN_W-1:0]        win_len,
  input  logic [NUM_CH*CNT_W-1:0] cnt_in,
  output logic                    ctr_clear,
  output logic                    gate,
  output logic                    busy,
  output logic                    done,
  ros_scan_readout_if.master      ser
);

  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FRAME_W = 4 + IDX_W + CNT_W + 1;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int SET_W   = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_SETTLE,
    S_SNAP,
    S_SHIFT
  } state_t;

  state_t                         state;
  logic [NUM_CH-1:0]              mask_lat;
  logic [WIN_W-1:0]               win_lat;
  logic                           cont_lat;
  logic [WIN_W-1:0]               win_cnt;
  logic [SET_W-1:0]               settle_cnt;
  logic [BIT_W-1:0]               bit_cnt;
  logic [IDX_W-1:0]               cur_ch;
  logic [FRAME_W-1:0]             sh;
  logic [NUM_CH-1:0][CNT_W-1:0]   snap;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_arr;

  logic                           restart;
  logic [WIN_W-1:0]               win_eff;
  logic [IDX_W:0]                 first_hit;
  logic [IDX_W:0]                 next_hit;
  logic [FRAME_W-1:0]             first_frame;
  logic [FRAME_W-1:0]             next_frame;

  // The packed layout of cnt_in already matches channel order.
  assign cnt_arr = cnt_in;

  // Lowest enabled channel with index >= lo; MSB of the result is "found".
  function automatic logic [IDX_W:0] find_from(input logic [NUM_CH-1:0] m,
                                               input int lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  function automatic logic [FRAME_W-1:0] frame_of(input logic [IDX_W-1:0] idx,
                                                  input logic [CNT_W-1:0] c);
    return {4'b1010, idx, c, ^{idx, c}};
  endfunction

  // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
  always_comb begin
    restart   = cont_lat & continuous;
    win_eff   = (win_len == '0) ? WIN_W'(1) : win_len;
    first_hit = find_from(mask_lat, 0);
    next_hit  = find_from(mask_lat, int'(cur_ch) + 1);
    // The first frame leaves in the same cycle the snapshot is written,
    // so it is built straight from the live counts.
    first_frame = frame_of(first_hit[IDX_W-1:0], cnt_arr[first_hit[IDX_W-1:0]]);
    next_frame  = frame_of(next_hit[IDX_W-1:0], snap[next_hit[IDX_W-1:0]]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      ctr_clear       <= 1'b0;
      gate            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      ser.ser_data    <= 1'b0;
      ser.ser_valid   <= 1'b0;
      ser.frame_start <= 1'b0;
      mask_lat        <= '0;
      win_lat         <= '0;
      cont_lat        <= 1'b0;
      win_cnt         <= '0;
      settle_cnt      <= '0;
      bit_cnt         <= '0;
      cur_ch          <= '0;
      sh              <= '0;
      // NOTE: the snapshot array is reset explicitly so stale counts never reach the serial output.
      snap            <= '0;
    end else if (ena) begin
      // Pulses default low; with ena low they simply hold (stretch).
      ctr_clear <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mask_lat  <= ch_mask;
            win_lat   <= win_eff;
            cont_lat  <= continuous;
            ctr_clear <= 1'b1;
            busy      <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          gate    <= 1'b1;
          win_cnt <= WIN_W'(1);
          state   <= S_GATE;
        end
        S_GATE: begin
          // win_cnt holds the number of gate-high cycles including this one.
          if (win_cnt == win_lat) begin
            gate       <= 1'b0;
            settle_cnt <= SET_W'(1);
            state      <= S_SETTLE;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE)) state <= S_SNAP;
          else                              settle_cnt <= settle_cnt + 1'b1;
        end
        S_SNAP: begin
          snap <= cnt_arr;
          if (first_hit[IDX_W]) begin
            cur_ch          <= first_hit[IDX_W-1:0];
            bit_cnt         <= '0;
            ser.ser_data    <= first_frame[FRAME_W-1];
            sh              <= {first_frame[FRAME_W-2:0], 1'b0};
            ser.ser_valid   <= 1'b1;
            ser.frame_start <= 1'b1;
            state           <= S_SHIFT;
          end else begin
            // Empty mask: the sweep ends without any frame.
            done <= 1'b1;
            if (restart) begin
              mask_lat  <= ch_mask;
              win_lat   <= win_eff;
              ctr_clear <= 1'b1;
              state     <= S_CLEAR;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_SHIFT: begin
          ser.frame_start <= 1'b0;
          if (bit_cnt != BIT_W'(FRAME_W - 1)) begin
            bit_cnt      <= bit_cnt + 1'b1;
            ser.ser_data <= sh[FRAME_W-1];
            sh           <= sh << 1;
          end else if (next_hit[IDX_W]) begin
            // Next frame follows with no gap cycle.
            cur_ch          <= next_hit[IDX_W-1:0];
            bit_cnt         <= '0;
            ser.ser_data    <= next_frame[FRAME_W-1];
            sh              <= {next_frame[FRAME_W-2:0], 1'b0};
            ser.frame_start <= 1'b1;
          end else begin
            ser.ser_data  <= 1'b0;
            ser.ser_valid <= 1'b0;
            done          <= 1'b1;
            // A new sweep needs both the request captured at start and the live level.
            if (restart) begin
              mask_lat  <= ch_mask;
              win_lat   <= win_eff;
              ctr_clear <= 1'b1;
              state     <= S_CLEAR;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
